// File: rtl/key_beep_pkg.sv
// Shared types and helpers for the key beep scheduler: key count, FSM states
// and the round-robin pick used to choose which pending key gets the buzzer.
package key_beep_pkg;

    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } beep_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // Search last+1, last+2, ... modulo NUM_KEYS; the nearest requester wins,
    // so the loop runs from the farthest candidate down to the nearest.
    function automatic rr_pick_t rr_pick(input logic [NUM_KEYS-1:0] req,
                                         input logic [1:0]          last);
        rr_pick_t   res;
        logic [1:0] cand;
        res.valid = 1'b0;
        res.idx   = 2'd0;
        for (int k = NUM_KEYS; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [1:0] idx);
        logic [NUM_KEYS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key input path: 2-flop synchronizer, mismatch-counting debouncer and a
// single-cycle pulse on each accepted press (release produces no pulse).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          state_q, state_d;
    logic          evt_q,   evt_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          press_raw;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        press_raw = ~sync2_q;
        state_d   = state_q;
        cnt_d     = '0;
        evt_d     = 1'b0;
        if (press_raw != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = press_raw;
                evt_d   = press_raw;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_evt = evt_q;

endmodule

// File: rtl/key_beep_scheduler.sv
// Shares one buzzer among four push-buttons: latches debounced presses,
// grants them round-robin and plays a per-key tone followed by a silent gap.
module key_beep_scheduler
    import key_beep_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BEEP_CYCLES     = 12_500_000,
    parameter int GAP_CYCLES      = 2_500_000,
    parameter int TONE_DIV        = 25_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_sw,
    output logic [NUM_KEYS-1:0] led,
    output logic                buzzer,
    output logic                busy
);

    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;
    localparam int TW = (TONE_DIV > 1)    ? $clog2(TONE_DIV)    : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    function automatic logic [TW-1:0] tone_reload(input logic [1:0] idx);
        return TW'((TONE_DIV >> idx) - 1);
    endfunction

    logic [NUM_KEYS-1:0] press_evt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_n    (key_sw[i]),
            .press_evt(press_evt[i])
        );
    end

    beep_state_t         state_q,    state_d;
    logic [1:0]          gnt_q,      gnt_d;
    logic [1:0]          last_q,     last_d;
    logic [NUM_KEYS-1:0] pending_q,  pending_d;
    logic [BW-1:0]       beep_tmr_q, beep_tmr_d;
    logic [GW-1:0]       gap_tmr_q,  gap_tmr_d;
    logic [TW-1:0]       tone_cnt_q, tone_cnt_d;
    logic                buzzer_q,   buzzer_d;
    logic                busy_q,     busy_d;
    logic [NUM_KEYS-1:0] led_q,      led_d;

    rr_pick_t            pick;
    logic [NUM_KEYS-1:0] served;
    logic [NUM_KEYS-1:0] grant_mask;

    // Outputs are derived from the next state so they change on the same
    // edge as the state they describe.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beep_tmr_d = beep_tmr_q;
        gap_tmr_d  = gap_tmr_q;
        tone_cnt_d = tone_cnt_q;
        buzzer_d   = buzzer_q;
        pick       = rr_pick(pending_q, last_q);
        served     = (state_q == BEEP) ? key_onehot(gnt_q) : '0;
        grant_mask = '0;

        case (state_q)
            IDLE: begin
                buzzer_d = 1'b0;
                if (pick.valid) begin
                    state_d    = BEEP;
                    gnt_d      = pick.idx;
                    last_d     = pick.idx;
                    grant_mask = key_onehot(pick.idx);
                    beep_tmr_d = BEEP_LAST;
                    tone_cnt_d = tone_reload(pick.idx);
                    buzzer_d   = 1'b1;
                end
            end
            BEEP: begin
                if (beep_tmr_q == '0) begin
                    state_d   = GAP;
                    gap_tmr_d = GAP_LAST;
                    buzzer_d  = 1'b0;
                end else begin
                    beep_tmr_d = beep_tmr_q - BW'(1);
                    if (tone_cnt_q == '0) begin
                        buzzer_d   = ~buzzer_q;
                        tone_cnt_d = tone_reload(gnt_q);
                    end else begin
                        tone_cnt_d = tone_cnt_q - TW'(1);
                    end
                end
            end
            GAP: begin
                buzzer_d = 1'b0;
                if (gap_tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_tmr_d = gap_tmr_q - GW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
            end
        endcase

        // A press of the key being played, or of the key granted this cycle,
        // is dropped rather than queued.
        pending_d = (pending_q | (press_evt & ~served)) & ~grant_mask;
        busy_d    = (state_d != IDLE);
        led_d     = ~(pending_d | ((state_d == BEEP) ? key_onehot(gnt_d) : '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 2'd0;
            last_q     <= 2'd3;
            pending_q  <= '0;
            beep_tmr_q <= '0;
            gap_tmr_q  <= '0;
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= '1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            beep_tmr_q <= beep_tmr_d;
            gap_tmr_q  <= gap_tmr_d;
            tone_cnt_q <= tone_cnt_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            led_q      <= led_d;
        end
    end

    assign led    = led_q;
    assign buzzer = buzzer_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_key_beep_scheduler.sv
// Self-checking bench for key_beep_scheduler: directed vector table, corner
// sequences and random key activity compared against a behavioural model.
module tb_key_beep_scheduler;

    localparam int DEB   = 4;
    localparam int BEEPC = 40;
    localparam int GAPC  = 8;
    localparam int TDIV  = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] key_sw = 4'h0;
    logic [3:0] led;
    logic       buzzer;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_beep_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .BEEP_CYCLES    (BEEPC),
        .GAP_CYCLES     (GAPC),
        .TONE_DIV       (TDIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key_sw(key_sw),
        .led   (led),
        .buzzer(buzzer),
        .busy  (busy)
    );

    // Behavioural model: debounce by a sliding window of the last DEB samples,
    // playback described by mode and elapsed cycles within that mode.
    bit [3:0] m_s1, m_s2, m_deb, m_evt, m_pend;
    int       m_last, m_gnt, m_mode, m_el;
    bit       m_hist[4][$];
    bit       m_valid = 1'b0;

    task automatic modelStep(input logic [3:0] k, input logic r);
        bit [3:0] raw, new_deb, new_evt, smask, gmask;
        bit       all_diff;
        int       pick;
        if (!r) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'h0; m_evt = 4'h0; m_pend = 4'h0;
            m_last = 3; m_gnt = 0; m_mode = 0; m_el = 0;
            for (int i = 0; i < 4; i++) m_hist[i].delete();
            return;
        end
        raw     = ~m_s2;
        new_deb = m_deb;
        new_evt = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_hist[i].push_back(raw[i]);
            if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
            all_diff = (m_hist[i].size() == DEB);
            foreach (m_hist[i][j]) if (m_hist[i][j] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) begin
                new_deb[i] = raw[i];
                new_evt[i] = raw[i];
            end
        end
        smask = (m_mode == 1) ? 4'(1 << m_gnt) : 4'h0;
        gmask = 4'h0;
        case (m_mode)
            0: if (m_pend != 4'h0) begin
                pick = -1;
                for (int d = 1; d <= 4; d++)
                    if (pick < 0 && m_pend[(m_last + d) % 4]) pick = (m_last + d) % 4;
                m_gnt = pick; m_last = pick; gmask = 4'(1 << pick);
                m_mode = 1; m_el = 0;
            end
            1: if (m_el == BEEPC - 1) begin m_mode = 2; m_el = 0; end else m_el++;
            default: if (m_el == GAPC - 1) begin m_mode = 0; m_el = 0; end else m_el++;
        endcase
        m_pend = (m_pend | (m_evt & ~smask)) & ~gmask;
        m_evt  = new_evt;
        m_deb  = new_deb;
        m_s2   = m_s1;
        m_s1   = k;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_led,
                               input logic e_buz, input logic e_busy);
        checks++;
        if (led !== e_led || buzzer !== e_buz || busy !== e_busy) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got led=%b buzzer=%b busy=%b, expected led=%b buzzer=%b busy=%b",
                     tag, $time, led, buzzer, busy, e_led, e_buz, e_busy);
        end
    endtask

    always @(posedge clk) begin
        modelStep(key_sw, rst_n);
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid)
            checkOutput("model", ~(m_pend | ((m_mode == 1) ? 4'(1 << m_gnt) : 4'h0)),
                        (m_mode == 1) && (((m_el / (TDIV >> m_gnt)) % 2) == 0),
                        m_mode != 0);
    end

    int   beep_starts = 0;
    logic busy_prev   = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) beep_starts++;
        busy_prev = busy;
    end

    typedef struct {
        logic [3:0] key;
        logic       rst;
        int         cycles;
        logic [3:0] e_led;
        logic       e_buz;
        logic       e_busy;
    } vec_t;
    vec_t vecs[$];

    task automatic addVec(input logic [3:0] k, input logic r, input int n,
                          input logic [3:0] el, input logic ebz, input logic eb);
        vec_t v;
        v.key = k; v.rst = r; v.cycles = n; v.e_led = el; v.e_buz = ebz; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic r);
        key_sw = k;
        rst_n  = r;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitBusy(input logic level, input int maxc, input string tag);
        int n = 0;
        while (busy !== level && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== level) begin
            failures++;
            $display("[TB] FAIL %s: busy=%b after %0d cycles, required %b", tag, busy, n, level);
        end
    endtask

    initial begin
        int starts0;
        // Reset with all keys held, then one beep each in order 0..3.
        addVec(4'h0, 1'b0,  5, 4'hF,    1'b0, 1'b0);
        addVec(4'h0, 1'b1,  7, 4'h0,    1'b0, 1'b0);
        addVec(4'h0, 1'b1,  1, 4'h0,    1'b1, 1'b1);
        addVec(4'h0, 1'b1, 39, 4'h0,    1'b1, 1'b1);
        addVec(4'h0, 1'b1,  1, 4'b0001, 1'b0, 1'b1);
        addVec(4'h0, 1'b1,  8, 4'b0001, 1'b0, 1'b0);
        addVec(4'h0, 1'b1,  1, 4'b0001, 1'b1, 1'b1);
        addVec(4'h0, 1'b1, 49, 4'b0011, 1'b1, 1'b1);
        addVec(4'h0, 1'b1, 49, 4'b0111, 1'b1, 1'b1);
        addVec(4'h0, 1'b1, 48, 4'hF,    1'b0, 1'b0);
        addVec(4'hF, 1'b1, 10, 4'hF,    1'b0, 1'b0);
        // Clean press of key 2: half-period 2.
        addVec(4'hB, 1'b1,  7, 4'hB,    1'b0, 1'b0);
        addVec(4'hB, 1'b1,  1, 4'hB,    1'b1, 1'b1);
        addVec(4'hB, 1'b1,  2, 4'hB,    1'b0, 1'b1);
        addVec(4'hB, 1'b1,  1, 4'hB,    1'b0, 1'b1);
        addVec(4'hB, 1'b1,  1, 4'hB,    1'b1, 1'b1);
        addVec(4'hB, 1'b1, 36, 4'hF,    1'b0, 1'b1);
        addVec(4'hB, 1'b1,  7, 4'hF,    1'b0, 1'b1);
        addVec(4'hB, 1'b1,  1, 4'hF,    1'b0, 1'b0);
        addVec(4'hF, 1'b1, 10, 4'hF,    1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].key, vecs[i].rst);
            waitEdges(vecs[i].cycles);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_led, vecs[i].e_buz, vecs[i].e_busy);
        end

        // Key 1 bounces, then settles pressed: exactly one beep.
        starts0 = beep_starts;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b1101 : 4'hF, 1'b1);
            waitEdges(2);
        end
        checkOutput("bounce_quiet", 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1101, 1'b1);
        waitBusy(1'b1, 30, "bounce_start");
        checkOutput("bounce_beep", 4'b1101, 1'b1, 1'b1);
        waitBusy(1'b0, 60, "bounce_end");
        waitEdges(20);
        checkOutput("bounce_after", 4'hF, 1'b0, 1'b0);
        checks++;
        if (beep_starts - starts0 != 1) begin
            failures++;
            $display("[TB] FAIL bounce_count: beeps=%0d, required 1", beep_starts - starts0);
        end
        applyStimulus(4'hF, 1'b1);
        waitEdges(10);

        // Keys 1 and 2 together after key 1 was last: key 2 first.
        applyStimulus(4'b1001, 1'b1);
        waitEdges(8);
        checkOutput("rr_key2", 4'b1001, 1'b1, 1'b1);
        waitEdges(49);
        checkOutput("rr_key1", 4'b1101, 1'b1, 1'b1);
        waitEdges(48);
        checkOutput("rr_idle", 4'hF, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b1);
        waitEdges(10);

        // Re-press of key 0 during its own beep is dropped; key 3 queues.
        applyStimulus(4'b1110, 1'b1);
        waitEdges(8);
        checkOutput("k0_beep", 4'b1110, 1'b1, 1'b1);
        applyStimulus(4'hF, 1'b1);
        waitEdges(8);
        applyStimulus(4'b0110, 1'b1);
        waitEdges(8);
        checkOutput("k0_repress", 4'b0110, 1'b1, 1'b1);
        waitEdges(24);
        checkOutput("k0_gap", 4'b0111, 1'b0, 1'b1);
        waitEdges(8);
        checkOutput("k3_idle", 4'b0111, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("k3_beep", 4'b0111, 1'b1, 1'b1);
        waitEdges(48);
        checkOutput("k3_done", 4'hF, 1'b0, 1'b0);
        waitEdges(10);
        checkOutput("k0_dropped", 4'hF, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b1);
        waitEdges(10);

        // Reset in the middle of a beep loses the queued request.
        applyStimulus(4'b1001, 1'b1);
        waitEdges(8);
        checkOutput("rst_beep", 4'b1001, 1'b1, 1'b1);
        waitEdges(9);
        applyStimulus(4'hF, 1'b0);
        waitEdges(1);
        checkOutput("rst_mid", 4'hF, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b1);
        waitEdges(60);
        checkOutput("rst_lost", 4'hF, 1'b0, 1'b0);

        // Random key activity with occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 60) != 0));
            waitEdges($urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
